// File: rtl/reg_file_alu_pipe_if.sv
// Operation/result bundle between the instruction decoder and the
// register-file/ALU pipeline.
interface reg_file_alu_pipe_if #(
   parameter int WIDTH = 8,
   parameter int NREGS = 16
);
   localparam int AW = $clog2(NREGS);

   logic             in_valid;
   logic [AW-1:0]    RA1;
   logic [AW-1:0]    RA2;
   logic [AW-1:0]    WA;
   logic [WIDTH-1:0] immediate;
   logic             write_enable;
   logic             ALUsrc;
   logic [2:0]       ALUControl;
   logic [WIDTH-1:0] ALUResult;
   logic             out_valid;
   logic             Zero;
   logic             Carry;
   logic             Negative;
   logic             Overflow;
   logic [WIDTH-1:0] cpu_out;

   modport master (
      output in_valid, RA1, RA2, WA, immediate, write_enable, ALUsrc, ALUControl,
      input  ALUResult, out_valid, Zero, Carry, Negative, Overflow, cpu_out
   );

   modport slave (
      input  in_valid, RA1, RA2, WA, immediate, write_enable, ALUsrc, ALUControl,
      output ALUResult, out_valid, Zero, Carry, Negative, Overflow, cpu_out
   );
endinterface

// File: rtl/reg_file_alu_pipe.sv
// Two-stage register-file/ALU pipeline: ID reads operands (with EX forwarding),
// EX computes, writes back and registers result plus Z/C/N/V flags.
module reg_file_alu_pipe #(
   parameter int WIDTH   = 8,
   parameter int NREGS   = 16,
   parameter int OUT_REG = NREGS - 1
) (
   input logic                CLK,
   input logic                RST_N,
   reg_file_alu_pipe_if.slave bus
);
   localparam int AW = $clog2(NREGS);
   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [AW-1:0] OUT_IDX = AW'(OUT_REG);

   logic [WIDTH-1:0] regs [NREGS];

   logic             id_valid;
   logic [WIDTH-1:0] id_a;
   logic [WIDTH-1:0] id_b;
   logic [AW-1:0]    id_wa;
   logic             id_we;
   logic [2:0]       id_op;

   logic [WIDTH-1:0] ex_res;
   logic             ex_c;
   logic             ex_v;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;

   logic             fwd1;
   logic             fwd2;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;
   logic [WIDTH-1:0] src_b;

   // The op sitting in EX has not written back yet, so a matching read takes its result.
   assign fwd1  = id_valid && id_we && (id_wa == bus.RA1);
   assign fwd2  = id_valid && id_we && (id_wa == bus.RA2);
   assign rd1   = fwd1 ? ex_res : regs[bus.RA1];
   assign rd2   = fwd2 ? ex_res : regs[bus.RA2];
   assign src_b = bus.ALUsrc ? bus.immediate : rd2;

   always_comb begin
      sum    = {1'b0, id_a} + {1'b0, id_b};
      diff   = {1'b0, id_a} - {1'b0, id_b};
      ex_res = '0;
      ex_c   = 1'b0;
      ex_v   = 1'b0;
      case (id_op)
         3'b000: begin
            ex_res = sum[WIDTH-1:0];
            ex_c   = sum[WIDTH];
            ex_v   = (id_a[WIDTH-1] == id_b[WIDTH-1]) && (ex_res[WIDTH-1] != id_a[WIDTH-1]);
         end
         3'b001: begin
            ex_res = diff[WIDTH-1:0];
            ex_c   = ~diff[WIDTH];
            ex_v   = (id_a[WIDTH-1] != id_b[WIDTH-1]) && (ex_res[WIDTH-1] != id_a[WIDTH-1]);
         end
         3'b010:  ex_res = id_a & id_b;
         3'b011:  ex_res = id_a | id_b;
         3'b100:  ex_res = id_a ^ id_b;
         3'b101:  ex_res = id_a << id_b[SW-1:0];
         3'b110:  ex_res = id_a >> id_b[SW-1:0];
         default: ex_res = id_b;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         id_valid      <= 1'b0;
         id_a          <= '0;
         id_b          <= '0;
         id_wa         <= '0;
         id_we         <= 1'b0;
         id_op         <= '0;
         bus.ALUResult <= '0;
         bus.out_valid <= 1'b0;
         bus.Zero      <= 1'b0;
         bus.Carry     <= 1'b0;
         bus.Negative  <= 1'b0;
         bus.Overflow  <= 1'b0;
      end else begin
         id_valid <= bus.in_valid;
         id_a     <= rd1;
         id_b     <= src_b;
         id_wa    <= bus.WA;
         id_we    <= bus.write_enable;
         id_op    <= bus.ALUControl;
         if (id_valid) begin
            if (id_we) regs[id_wa] <= ex_res;
            bus.ALUResult <= ex_res;
            bus.out_valid <= 1'b1;
            bus.Zero      <= (ex_res == '0);
            bus.Carry     <= ex_c;
            bus.Negative  <= ex_res[WIDTH-1];
            bus.Overflow  <= ex_v;
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end

   assign bus.cpu_out = regs[OUT_IDX];
endmodule

// File: tb/tb_reg_file_alu_pipe.sv
// Scoreboard bench for reg_file_alu_pipe: 8-bit/16-reg main instance plus a
// 16-bit/4-reg instance for the parameter sweep.
module tb_reg_file_alu_pipe;
   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        n;
      logic        v;
      int          cyc;
   } exp_t;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   sb_en = 1'b0;

   exp_t sbq[$];
   exp_t q16[$];
   exp_t last;
   int   mreg[16];
   int   m16[4];

   reg_file_alu_pipe_if #(.WIDTH(8), .NREGS(16)) bus ();
   reg_file_alu_pipe_if #(.WIDTH(16), .NREGS(4)) bus16 ();

   reg_file_alu_pipe #(.WIDTH(8), .NREGS(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .bus(bus.slave)
   );
   reg_file_alu_pipe #(.WIDTH(16), .NREGS(4)) dut16 (
      .CLK(CLK), .RST_N(RST_N), .bus(bus16.slave)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic exp_t alu_model(input int w, input int op, input longint a, input longint b);
      exp_t   e;
      longint mask, half, full, sa, sb, ss, r;
      int     lg;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      lg = 0;
      while ((1 << lg) < w) lg++;
      sa = (a >= half) ? a - (longint'(1) << w) : a;
      sb = (b >= half) ? b - (longint'(1) << w) : b;
      e.c = 1'b0;
      e.v = 1'b0;
      r = 0;
      case (op)
         0: begin
            full = a + b;
            r = full & mask;
            e.c = (full > mask);
            ss = sa + sb;
            e.v = (ss >= half) || (ss < -half);
         end
         1: begin
            r = (a - b) & mask;
            e.c = (a >= b);
            ss = sa - sb;
            e.v = (ss >= half) || (ss < -half);
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (a << (b % (longint'(1) << lg))) & mask;
         6: r = a >> (b % (longint'(1) << lg));
         default: r = b;
      endcase
      e.res = 32'(r);
      e.z   = (r == 0);
      e.n   = (((r >> (w - 1)) & 1) != 0);
      e.cyc = 0;
      return e;
   endfunction

   task automatic issue(input int op, input int ra1, input int ra2, input int wa,
                        input int imm, input bit we, input bit src);
      exp_t e;
      bus.in_valid     = 1'b1;
      bus.ALUControl   = 3'(op);
      bus.RA1          = 4'(ra1);
      bus.RA2          = 4'(ra2);
      bus.WA           = 4'(wa);
      bus.immediate    = 8'(imm);
      bus.write_enable = we;
      bus.ALUsrc       = src;
      e = alu_model(8, op, longint'(mreg[ra1]), src ? longint'(imm & 8'hFF) : longint'(mreg[ra2]));
      e.cyc = cyc + 2;
      sbq.push_back(e);
      if (we) mreg[wa] = int'(e.res);
      @(posedge CLK); #1;
   endtask

   task automatic issue16(input int op, input int ra1, input int ra2, input int wa,
                          input int imm, input bit src);
      exp_t e;
      bus16.in_valid     = 1'b1;
      bus16.ALUControl   = 3'(op);
      bus16.RA1          = 2'(ra1);
      bus16.RA2          = 2'(ra2);
      bus16.WA           = 2'(wa);
      bus16.immediate    = 16'(imm);
      bus16.write_enable = 1'b1;
      bus16.ALUsrc       = src;
      e = alu_model(16, op, longint'(m16[ra1]), src ? longint'(imm & 16'hFFFF) : longint'(m16[ra2]));
      e.cyc = cyc + 2;
      q16.push_back(e);
      m16[wa] = int'(e.res);
      @(posedge CLK); #1;
   endtask

   task automatic bubble(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (sb_en) begin
         if (bus.out_valid) begin
            if (sbq.size() == 0) chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            else begin
               e = sbq.pop_front();
               chk("result",   32'(bus.ALUResult), e.res);
               chk("zero",     32'(bus.Zero),      32'(e.z));
               chk("carry",    32'(bus.Carry),     32'(e.c));
               chk("negative", 32'(bus.Negative),  32'(e.n));
               chk("overflow", 32'(bus.Overflow),  32'(e.v));
               chk("latency",  32'(cyc),           32'(e.cyc));
               last = e;
            end
         end else begin
            chk("hold_result", 32'(bus.ALUResult), last.res);
            chk("hold_flags", 32'({bus.Zero, bus.Carry, bus.Negative, bus.Overflow}),
                32'({last.z, last.c, last.n, last.v}));
         end
         if (bus16.out_valid) begin
            if (q16.size() == 0) chk("w16_spurious_out_valid", 32'(bus16.out_valid), 32'd0);
            else begin
               e = q16.pop_front();
               chk("w16_result",   32'(bus16.ALUResult), e.res);
               chk("w16_zero",     32'(bus16.Zero),      32'(e.z));
               chk("w16_carry",    32'(bus16.Carry),     32'(e.c));
               chk("w16_negative", 32'(bus16.Negative),  32'(e.n));
               chk("w16_latency",  32'(cyc),             32'(e.cyc));
            end
         end
      end
   end

   initial begin
      int old15;
      bus.in_valid = 0; bus.ALUControl = 0; bus.RA1 = 0; bus.RA2 = 0; bus.WA = 0;
      bus.immediate = 0; bus.write_enable = 0; bus.ALUsrc = 0;
      bus16.in_valid = 0; bus16.ALUControl = 0; bus16.RA1 = 0; bus16.RA2 = 0; bus16.WA = 0;
      bus16.immediate = 0; bus16.write_enable = 0; bus16.ALUsrc = 0;
      foreach (mreg[i]) mreg[i] = 0;
      foreach (m16[i]) m16[i] = 0;
      last = '{res: 0, z: 0, c: 0, n: 0, v: 0, cyc: 0};

      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_cpu_out",   32'(bus.cpu_out),   32'd0);

      // two writes in flight, then reset lands on the third edge
      bus.in_valid = 1; bus.ALUControl = 3'b000; bus.RA1 = 0; bus.WA = 15;
      bus.immediate = 8'h11; bus.ALUsrc = 1; bus.write_enable = 1;
      @(posedge CLK); #1;
      bus.RA1 = 15; bus.WA = 1; bus.immediate = 8'h22;
      @(posedge CLK); #1;
      bus.in_valid = 0; RST_N = 1'b0;
      @(posedge CLK); #1;
      chk("inflight_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("inflight_rst_result",    32'(bus.ALUResult), 32'd0);
      chk("inflight_rst_flags", 32'({bus.Zero, bus.Carry, bus.Negative, bus.Overflow}), 32'd0);
      chk("inflight_rst_cpu_out",   32'(bus.cpu_out),   32'd0);
      RST_N = 1'b1;
      sb_en = 1'b1;

      for (int i = 0; i < 16; i++) issue(7, 0, i, 0, 0, 1'b0, 1'b0);

      issue(7, 0, 0, 1, 8'h05, 1'b1, 1'b1);
      issue(7, 0, 0, 2, 8'hFB, 1'b1, 1'b1);
      issue(0, 1, 0, 3, 8'h03, 1'b1, 1'b1);
      issue(0, 3, 3, 4, 0, 1'b1, 1'b0);

      issue(7, 0, 0, 5, 8'h7F, 1'b1, 1'b1);
      issue(0, 5, 0, 5, 8'h01, 1'b1, 1'b1);
      issue(7, 0, 0, 6, 8'hFF, 1'b1, 1'b1);
      issue(0, 6, 0, 7, 8'h01, 1'b1, 1'b1);
      issue(7, 0, 0, 8, 8'h03, 1'b1, 1'b1);
      issue(1, 8, 0, 9, 8'h05, 1'b1, 1'b1);
      issue(1, 9, 8, 9, 0, 1'b1, 1'b0);

      issue(7, 0, 0, 10, 8'hF0, 1'b1, 1'b1);
      issue(2, 10, 0, 10, 8'h3C, 1'b1, 1'b1);
      issue(7, 0, 0, 11, 8'hFF, 1'b1, 1'b1);
      issue(4, 11, 11, 11, 0, 1'b1, 1'b0);
      issue(7, 0, 0, 12, 8'h81, 1'b1, 1'b1);
      issue(5, 12, 0, 12, 8'h01, 1'b1, 1'b1);
      issue(7, 0, 0, 13, 8'h80, 1'b1, 1'b1);
      issue(6, 13, 0, 13, 8'h07, 1'b1, 1'b1);
      issue(3, 12, 13, 0, 0, 1'b1, 1'b0);

      bubble(3);
      old15 = mreg[15];
      issue(7, 0, 0, 15, 8'hA5, 1'b1, 1'b1);
      bus.in_valid = 0;
      chk("cpu_out_before_retire", 32'(bus.cpu_out), 32'(old15));
      bubble(1);
      chk("cpu_out_after_retire", 32'(bus.cpu_out), 32'h0A5);
      bubble(2);

      for (int i = 0; i < 60; i++) begin
         issue($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 2));
      end
      bubble(1);

      issue16(7, 0, 0, 1, 16'hFFFF, 1'b1);
      issue16(0, 1, 0, 2, 16'h0001, 1'b1);
      issue16(0, 1, 2, 3, 0, 1'b0);
      bus16.in_valid = 0;

      for (int i = 0; i < 20 && (sbq.size() != 0 || q16.size() != 0); i++) @(posedge CLK);
      @(negedge CLK); #1;
      chk("drain_main", 32'(sbq.size()), 32'd0);
      chk("drain_w16",  32'(q16.size()), 32'd0);
      chk("final_cpu_out",     32'(bus.cpu_out),   32'(mreg[15]));
      chk("w16_final_cpu_out", 32'(bus16.cpu_out), 32'(m16[3]));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/reg_file_alu_pipe.md
Name: reg_file_alu_pipe

Overview:
- Parametrised two-stage pipelined successor to the 8-bit single-cycle register-file/ALU datapath.
- Stage ID reads the register file and captures operands. Stage EX runs an 8-operation ALU, writes back, and registers the result and flags.
- Adds valid tracking, EX-to-ID forwarding, carry/negative/overflow flags and a configurable output register.
- Sits between the instruction decoder and the CPU output port.

Parameters:
- WIDTH, 8, datapath and register width in bits (>=4).
- NREGS, 16, number of registers (power of 2, >=2). AW = $clog2(NREGS) is derived.
- OUT_REG, NREGS-1, index of the register continuously driven on cpu_out.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  synchronous active-low reset.
- in_valid  input  1  operation presented this cycle.
- RA1  input  AW  source register A address.
- RA2  input  AW  source register B address.
- WA  input  AW  destination register address.
- immediate  input  WIDTH  immediate operand.
- write_enable  input  1  write result to WA.
- ALUsrc  input  1  0: SrcB=RD2; 1: SrcB=immediate.
- ALUControl  input  3  ALU operation.
- ALUResult  output  WIDTH  registered EX result.
- out_valid  output  1  ALUResult and flags belong to a completed op.
- Zero  output  1  registered zero flag.
- Carry  output  1  registered carry flag.
- Negative  output  1  registered negative flag.
- Overflow  output  1  registered overflow flag.
- cpu_out  output  WIDTH  current contents of register OUT_REG.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - All registers, ID/EX pipeline registers, ALUResult, all flags and out_valid go to 0.
  - Reset has priority over any same-edge write, so an in-flight op is discarded.
  - cpu_out reads 0 the cycle after reset.
- Accept rule: no backpressure; an op is accepted every cycle in_valid=1. in_valid=0 inserts a bubble.
- Edge E0 (ID capture): latch id_valid=in_valid and RD1, RD2/immediate (selected by ALUsrc), WA, write_enable and ALUControl.
- Cycle after E0: EX computes combinationally from the ID registers.
- Edge E1 (EX retire), only when id_valid=1:
  - If write_enable=1, regs[WA] <= result.
  - ALUResult, all four flags and out_valid=1 are registered.
- When id_valid=0 at E1: out_valid <= 0; ALUResult and flags hold their values.
- Latency: out_valid rises 2 edges after the in_valid edge. Throughput is 1 op/cycle.
- Forwarding: when ID reads RA1 or RA2 while EX holds a valid op with write_enable=1 and WA equal to that address, ID captures the EX result instead of the stale register value. Back-to-back dependent ops therefore never stall.
- Register write-after-read ordering: at the same edge, the EX write lands and the new ID capture uses the forwarded value.
- ALU operations (all modulo 2^WIDTH):
  - 000 ADD: C = carry-out; V = signed overflow.
  - 001 SUB (A-B): C = 1 iff A >= B unsigned; V = signed overflow.
  - 010 AND, 011 OR, 100 XOR: C = 0, V = 0.
  - 101 SHL: A << SrcB[AW'-1:0], where AW' = $clog2(WIDTH); C = 0, V = 0.
  - 110 SHR: logical shift right by the same amount; C = 0, V = 0.
  - 111 PASSB: result = SrcB; C = 0, V = 0.
- Flag definitions: Z = (result == 0); N = result[WIDTH-1].
- cpu_out is combinational from regs[OUT_REG]. A write to OUT_REG is visible the cycle after E1.
- Writes to any index, including 0, are permitted. No register is hardwired.
- Unused read ports return the register contents and have no side effects.

Test Plan:
- Reset with ops in flight: issue ADD at edges 1 and 2, assert RST_N=0 at edge 3 -> out_valid=0, all regs 0, and no write from either op is retained.
- Immediate load then pipeline: PASSB imm=0x05 to R1, then PASSB imm=0xFB to R2 -> out_valid pulses 2 edges later with ALUResult 0x05 then 0xFB; N=1 for 0xFB.
- Back-to-back forwarding: R1=0x05. ADD R3=R1+imm 0x03, then next cycle ADD R4=R3+R3 -> ALUResult 0x08 then 0x10, with no stall cycle.
- Carry/overflow, WIDTH=8: ADD 0x7F+0x01 -> 0x80, V=1, C=0, N=1. ADD 0xFF+0x01 -> 0x00, Z=1, C=1. SUB 0x03-0x05 -> 0xFE, C=0, N=1.
- Logic and shifts: AND 0xF0&0x3C=0x30; XOR 0xFF^0xFF=0x00 with Z=1; SHL 0x81 by 1 = 0x02; SHR 0x80 by 7 = 0x01.
- cpu_out and bubbles: write 0xA5 to R15 with in_valid gaps between ops -> cpu_out=0xA5 the cycle after retire; out_valid=0 on bubble cycles while ALUResult holds its last value.
- Parameter sweep: WIDTH=16, NREGS=4 -> ADD 0xFFFF+1 gives Z=1 and C=1.
